// File: rtl/bru_pkg.sv
// rtl/bru_pkg.sv - shared types, constants and the mispredict rule for the branch resolve unit
package bru_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } bru_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } bru_state_t;

  localparam logic [31:0] BRU_PC_INCR = 32'd4;

  // A not-taken prediction that resolves not-taken is correct whatever the targets are.
  function automatic logic bru_is_mispredict(input bru_entry_t e, input logic taken,
                                             input logic [31:0] target);
    return (e.pred_taken != taken) ||
           (e.pred_taken && taken && (e.pred_target != target));
  endfunction

endpackage

// File: rtl/bru_pred_queue.sv
// rtl/bru_pred_queue.sv - in-order FIFO of fetch-stage branch predictions
module bru_pred_queue
  import bru_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_push,
  input  bru_entry_t i_push_data,
  input  logic       i_pop,
  input  logic       i_clear,
  output logic       o_full,
  output logic       o_empty,
  output bru_entry_t o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  bru_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // Clear wins over push/pop so a mispredict leaves the queue empty.
  assign w_push = i_push && !o_full && !i_clear;
  assign w_pop  = i_pop && !o_empty && !i_clear;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - pairs predictions with execute outcomes, updates BTB, redirects and flushes
// Optional counters bru_stat_resolved/bru_stat_mispredict are built when BRU_STATS_EN is defined.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int QUEUE_DEPTH  = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        bru_clk,
  input  logic        bru_reset,
  input  logic        bru_fetch_valid,
  input  logic [31:0] bru_fetch_pc,
  input  logic        bru_fetch_pred_taken,
  input  logic [31:0] bru_fetch_pred_target,
  output logic        bru_fetch_ready,
  input  logic        bru_ex_valid,
  input  logic        bru_ex_taken,
  input  logic [31:0] bru_ex_target,
  output logic        bru_btb_write,
  output logic [31:0] bru_btb_new_pc,
  output logic [31:0] bru_btb_data,
  output logic        bru_btb_branch_taken,
  output logic        bru_redirect,
  output logic [31:0] bru_redirect_pc,
  output logic        bru_flush,
  output logic        bru_underflow
`ifdef BRU_STATS_EN
  ,
  output logic [31:0] bru_stat_resolved,
  output logic [31:0] bru_stat_mispredict
`endif
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);

  bru_state_t  r_state;
  bru_state_t  w_state_nxt;
  logic [FC_W-1:0] r_flush_cnt;
  logic [FC_W-1:0] w_flush_cnt_nxt;

  logic        w_full;
  logic        w_empty;
  bru_entry_t  w_head;
  bru_entry_t  w_push_data;
  logic        w_ready;
  logic        w_pop;
  logic        w_push;
  logic        w_mispredict;
  logic        w_underflow_evt;
  logic [31:0] w_correct_pc;

  logic        r_btb_write;
  logic [31:0] r_btb_new_pc;
  logic [31:0] r_btb_data;
  logic        r_btb_branch_taken;
  logic        r_redirect;
  logic [31:0] r_redirect_pc;
  logic        r_underflow;

  assign w_ready         = (r_state == IDLE) && !w_full;
  assign w_pop           = bru_ex_valid && (r_state == IDLE) && !w_empty;
  assign w_underflow_evt = bru_ex_valid && (r_state == IDLE) && w_empty;
  assign w_mispredict    = w_pop && bru_is_mispredict(w_head, bru_ex_taken, bru_ex_target);
  assign w_push          = bru_fetch_valid && w_ready && !w_mispredict;
  assign w_correct_pc    = bru_ex_taken ? bru_ex_target : (w_head.pc + BRU_PC_INCR);

  assign w_push_data.pc          = bru_fetch_pc;
  assign w_push_data.pred_taken  = bru_fetch_pred_taken;
  assign w_push_data.pred_target = bru_fetch_pred_target;

  bru_pred_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .i_clk       (bru_clk),
    .i_reset     (bru_reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_clear     (w_mispredict),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (w_head)
  );

  always_ff @(posedge bru_clk) begin
    if (bru_reset) begin
      r_state     <= IDLE;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  // The counter holds the flush cycles remaining after the current one.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    case (r_state)
      IDLE: begin
        if (w_mispredict) begin
          w_state_nxt     = FLUSH;
          w_flush_cnt_nxt = FC_LOAD;
        end
      end
      FLUSH: begin
        if (r_flush_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - FC_ONE;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_flush_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge bru_clk) begin
    if (bru_reset) begin
      r_btb_write        <= 1'b0;
      r_btb_new_pc       <= '0;
      r_btb_data         <= '0;
      r_btb_branch_taken <= 1'b0;
      r_redirect         <= 1'b0;
      r_redirect_pc      <= '0;
      r_underflow        <= 1'b0;
    end else begin
      r_btb_write <= w_pop;
      r_redirect  <= w_mispredict;
      if (w_pop) begin
        r_btb_new_pc       <= w_head.pc;
        r_btb_data         <= bru_ex_target;
        r_btb_branch_taken <= bru_ex_taken;
      end
      if (w_mispredict) begin
        r_redirect_pc <= w_correct_pc;
      end
      if (w_underflow_evt) begin
        r_underflow <= 1'b1;
      end
    end
  end

`ifdef BRU_STATS_EN
  logic [31:0] r_stat_resolved;
  logic [31:0] r_stat_mispredict;

  always_ff @(posedge bru_clk) begin
    if (bru_reset) begin
      r_stat_resolved   <= '0;
      r_stat_mispredict <= '0;
    end else begin
      if (w_pop && (r_stat_resolved != 32'hFFFF_FFFF)) begin
        r_stat_resolved <= r_stat_resolved + 32'd1;
      end
      if (w_mispredict && (r_stat_mispredict != 32'hFFFF_FFFF)) begin
        r_stat_mispredict <= r_stat_mispredict + 32'd1;
      end
    end
  end

  assign bru_stat_resolved   = r_stat_resolved;
  assign bru_stat_mispredict = r_stat_mispredict;
`endif

  assign bru_fetch_ready      = w_ready;
  assign bru_btb_write        = r_btb_write;
  assign bru_btb_new_pc       = r_btb_new_pc;
  assign bru_btb_data         = r_btb_data;
  assign bru_btb_branch_taken = r_btb_branch_taken;
  assign bru_redirect         = r_redirect;
  assign bru_redirect_pc      = r_redirect_pc;
  assign bru_flush            = (r_state == FLUSH);
  assign bru_underflow        = r_underflow;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed and randomized bench against a queue-based reference model
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int FLUSH = 2;

  typedef struct {
    logic [31:0] pc;
    bit          taken;
    logic [31:0] target;
  } pred_t;

  logic        bru_clk = 1'b0;
  logic        bru_reset = 1'b1;
  logic        bru_fetch_valid = 1'b0;
  logic [31:0] bru_fetch_pc = '0;
  logic        bru_fetch_pred_taken = 1'b0;
  logic [31:0] bru_fetch_pred_target = '0;
  logic        bru_fetch_ready;
  logic        bru_ex_valid = 1'b0;
  logic        bru_ex_taken = 1'b0;
  logic [31:0] bru_ex_target = '0;
  logic        bru_btb_write;
  logic [31:0] bru_btb_new_pc;
  logic [31:0] bru_btb_data;
  logic        bru_btb_branch_taken;
  logic        bru_redirect;
  logic [31:0] bru_redirect_pc;
  logic        bru_flush;
  logic        bru_underflow;
`ifdef BRU_STATS_EN
  logic [31:0] bru_stat_resolved;
  logic [31:0] bru_stat_mispredict;
`endif

  branch_resolve_unit #(
    .QUEUE_DEPTH  (DEPTH),
    .FLUSH_CYCLES (FLUSH)
  ) dut (
    .bru_clk               (bru_clk),
    .bru_reset             (bru_reset),
    .bru_fetch_valid       (bru_fetch_valid),
    .bru_fetch_pc          (bru_fetch_pc),
    .bru_fetch_pred_taken  (bru_fetch_pred_taken),
    .bru_fetch_pred_target (bru_fetch_pred_target),
    .bru_fetch_ready       (bru_fetch_ready),
    .bru_ex_valid          (bru_ex_valid),
    .bru_ex_taken          (bru_ex_taken),
    .bru_ex_target         (bru_ex_target),
    .bru_btb_write         (bru_btb_write),
    .bru_btb_new_pc        (bru_btb_new_pc),
    .bru_btb_data          (bru_btb_data),
    .bru_btb_branch_taken  (bru_btb_branch_taken),
    .bru_redirect          (bru_redirect),
    .bru_redirect_pc       (bru_redirect_pc),
    .bru_flush             (bru_flush),
    .bru_underflow         (bru_underflow)
`ifdef BRU_STATS_EN
    ,
    .bru_stat_resolved     (bru_stat_resolved),
    .bru_stat_mispredict   (bru_stat_mispredict)
`endif
  );

  always #5 bru_clk = ~bru_clk;

  int n_checks = 0;
  int n_errors = 0;

  pred_t       q[$];
  int          flush_left = 0;
  bit          e_under = 0;
  bit          e_write = 0;
  bit          e_redirect = 0;
  bit          e_chk_data = 0;
  bit          e_chk_rpc = 0;
  logic [31:0] e_newpc = '0;
  logic [31:0] e_data = '0;
  bit          e_btaken = 0;
  logic [31:0] e_rpc = '0;
  longint      e_stat_res = 0;
  longint      e_stat_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare registered outputs after the edge.
  task automatic step(input bit rst, input bit fv, input logic [31:0] pc, input bit pt,
                      input logic [31:0] ptgt, input bit ev, input bit et,
                      input logic [31:0] etgt);
    bit          can_push;
    bit          mis;
    pred_t       h;
    logic [31:0] act_next;
    logic [31:0] pred_next;
    bru_reset             = rst;
    bru_fetch_valid       = fv;
    bru_fetch_pc          = pc;
    bru_fetch_pred_taken  = pt;
    bru_fetch_pred_target = ptgt;
    bru_ex_valid          = ev;
    bru_ex_taken          = et;
    bru_ex_target         = etgt;
    can_push = (flush_left == 0) && (q.size() < DEPTH);
    check("fetch_ready", {31'd0, bru_fetch_ready}, {31'd0, can_push});

    e_write = 0;
    e_redirect = 0;
    e_chk_data = 0;
    e_chk_rpc = 0;
    if (rst) begin
      q.delete();
      flush_left = 0;
      e_under = 0;
      e_newpc = '0;
      e_data = '0;
      e_btaken = 0;
      e_rpc = '0;
      e_chk_data = 1;
      e_chk_rpc = 1;
      e_stat_res = 0;
      e_stat_mis = 0;
    end else if (flush_left > 0) begin
      flush_left--;
    end else begin
      mis = 0;
      if (ev) begin
        if (q.size() == 0) begin
          e_under = 1;
        end else begin
          h = q.pop_front();
          e_write = 1;
          e_chk_data = 1;
          e_newpc = h.pc;
          e_data = etgt;
          e_btaken = et;
          act_next = et ? etgt : h.pc + 32'd4;
          pred_next = h.taken ? h.target : h.pc + 32'd4;
          mis = (h.taken != et) || (pred_next != act_next);
          if (e_stat_res < 64'hFFFF_FFFF) e_stat_res++;
          if (mis) begin
            e_redirect = 1;
            e_chk_rpc = 1;
            e_rpc = act_next;
            flush_left = FLUSH;
            q.delete();
            if (e_stat_mis < 64'hFFFF_FFFF) e_stat_mis++;
          end
        end
      end
      if (fv && can_push && !mis) q.push_back('{pc: pc, taken: pt, target: ptgt});
    end

    @(posedge bru_clk);
    #1;
    check("btb_write", {31'd0, bru_btb_write}, {31'd0, e_write});
    check("redirect", {31'd0, bru_redirect}, {31'd0, e_redirect});
    check("flush", {31'd0, bru_flush}, {31'd0, flush_left > 0});
    check("underflow", {31'd0, bru_underflow}, {31'd0, e_under});
    if (e_chk_data) begin
      check("btb_new_pc", bru_btb_new_pc, e_newpc);
      check("btb_data", bru_btb_data, e_data);
      check("btb_taken", {31'd0, bru_btb_branch_taken}, {31'd0, e_btaken});
    end
    if (e_chk_rpc) check("redirect_pc", bru_redirect_pc, e_rpc);
`ifdef BRU_STATS_EN
    check("stat_resolved", bru_stat_resolved, e_stat_res[31:0]);
    check("stat_mispredict", bru_stat_mispredict, e_stat_mis[31:0]);
`endif
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(0, 2))
      0:       t = 32'h200;
      1:       t = 32'h300;
      default: t = 32'h400;
    endcase
    return t;
  endfunction

  initial begin
    logic [31:0] pc;
    logic [31:0] tgt;
    bit          fv;
    bit          pt;
    bit          ev;
    bit          et;

    repeat (2) @(posedge bru_clk);
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // Correct taken prediction
    step(0, 1, 32'h100, 1, 32'h200, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 32'h200);
    idle();

    // Predicted not-taken, resolved taken: redirect and flush
    step(0, 1, 32'h104, 0, 32'h0, 0, 0, 0);
    step(0, 1, 32'h500, 1, 32'h600, 1, 1, 32'h300);
    step(0, 1, 32'h504, 1, 32'h600, 0, 0, 0);
    step(0, 1, 32'h508, 1, 32'h600, 1, 0, 0);
    idle();

    // Predicted taken, resolved not-taken: fall-through redirect
    step(0, 1, 32'h108, 1, 32'h400, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 32'h400);
    idle(); idle(); idle();

    // Fall-through PC wraps at the top of the address space
    step(0, 1, 32'hFFFF_FFFC, 1, 32'h40, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 32'h40);
    idle(); idle();

    // Fill, push refused while full with a simultaneous correct pop, then pointer wrap
    for (int i = 0; i < DEPTH; i++) step(0, 1, 32'h1000 + 32'(i * 4), 1, 32'h2000 + 32'(i), 0, 0, 0);
    step(0, 1, 32'h1F00, 1, 32'h2F00, 1, 1, q[0].target);
    for (int i = 0; i < 10; i++) step(0, 1, 32'h3000 + 32'(i * 4), 1, 32'h4000 + 32'(i), 1, 1, q[0].target);
    while (q.size() > 0) step(0, 0, 0, 0, 0, 1, 1, q[0].target);

    // Underflow is sticky until reset
    step(0, 0, 0, 0, 0, 1, 1, 32'h123);
    idle();
    step(0, 1, 32'h200, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a flush
    step(0, 1, 32'h104, 0, 32'h0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 32'h300);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle();

    for (int n = 0; n < 3000; n++) begin
      fv  = ($urandom_range(0, 99) < 60);
      pc  = {$urandom(), 2'b00} >> 0;
      pt  = $urandom_range(0, 1) == 1;
      tgt = pick_target();
      ev  = ($urandom_range(0, 99) < 40);
      if (q.size() > 0 && $urandom_range(0, 99) < 70) begin
        et = q[0].taken;
        step($urandom_range(0, 199) == 0, fv, pc, pt, tgt, ev, et, et ? q[0].target : pick_target());
      end else begin
        et = $urandom_range(0, 1) == 1;
        step($urandom_range(0, 199) == 0, fv, pc, pt, tgt, ev, et, pick_target());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
